// File: rtl/psram_fetch_pkg.sv
// Shared types and constants for the PSRAM line fetcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psram_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SET_ADDR,
        STREAM
    } fetch_state_t;

    localparam int   PSRAM_ADDR_W   = 24;
    localparam logic PSRAM_CMD_READ = 1'b0;

endpackage

// File: rtl/psram_byte_fifo.sv
// Synchronous show-ahead FIFO; head entry is presented on o_data while not empty.
// Latency: a pushed word is visible on o_data the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_flush           synchronous clear; overrides push and pop
//   i_push, i_data    write strobe and data
//   i_pop             read strobe (ignored while empty)
//   o_data            head entry (0 while empty)
//   o_count           occupancy, 0..DEPTH
//   o_full, o_empty   occupancy flags
module psram_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A simultaneous pop frees the slot, so push-when-full is fine then.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/psram_line_fetcher.sv
// Fetches one framebuffer scanline from PSRAM per line_request into a byte FIFO for the pixel path.
// Latency: request->set_address 1 cycle, set_address->first byte request 1 cycle, byte->pixel_data 1 cycle.
// Backpressure: byte requests stall while the FIFO has no free slot (one request outstanding max).
// Ports:
//   sysclk, reset                 clock, asynchronous active-high reset
//   line_request, line_number     start a fetch of line_number (accepted only when idle)
//   line_abort                    stop fetch, flush FIFO, forget the outstanding byte
//   busy                          fetch in progress
//   psram_rw, psram_set_address,
//   psram_address,
//   psram_next_byte_needed        PSRAM controller command side
//   psram_byte, psram_byte_valid  returned data
//   pixel_data/valid/ready        show-ahead output stream
//   overflow                      sticky: byte dropped because FIFO was full
//   underrun                      consumer ready, FIFO empty, fetch still running
//   underrun_count                saturating underrun counter, present only when
//                                 PSRAM_FETCH_UNDERRUN_COUNT_EN is defined
module psram_line_fetcher
    import psram_fetch_pkg::*;
#(
    parameter int                      BYTES_PER_LINE = 320,
    parameter int                      FIFO_DEPTH     = 16,
    parameter logic [PSRAM_ADDR_W-1:0] BASE_ADDRESS   = 24'h0,
    parameter int                      LINE_BITS      = 10
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic                    line_request,
    input  logic [LINE_BITS-1:0]    line_number,
    input  logic                    line_abort,
    output logic                    busy,
    output logic                    psram_rw,
    output logic                    psram_set_address,
    output logic [PSRAM_ADDR_W-1:0] psram_address,
    output logic                    psram_next_byte_needed,
    input  logic [7:0]              psram_byte,
    input  logic                    psram_byte_valid,
    output logic [7:0]              pixel_data,
    output logic                    pixel_valid,
    input  logic                    pixel_ready,
    output logic                    overflow,
    output logic                    underrun
`ifdef PSRAM_FETCH_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]             underrun_count
`endif
);

    localparam int CNT_W  = $clog2(BYTES_PER_LINE + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t              r_state;
    fetch_state_t              w_state_nxt;
    logic [PSRAM_ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]          r_remaining;
    logic [CNT_W-1:0]          r_req_left;
    logic                      r_outstanding;
    logic                      r_overflow;

    logic [PSRAM_ADDR_W-1:0]   w_line_addr;
    logic                      w_accept;
    logic                      w_issue;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic [FCNT_W-1:0]         w_fifo_count;

    // Address arithmetic is done in 24 bits so it wraps at the top of PSRAM.
    assign w_line_addr = BASE_ADDRESS
                       + PSRAM_ADDR_W'(line_number) * PSRAM_ADDR_W'(BYTES_PER_LINE);

    assign w_accept = (r_state == IDLE) && line_request && !line_abort;

    // Credit rule: only request when the returning byte is guaranteed a slot.
    assign w_issue = (r_state == STREAM) && !r_outstanding
                  && (r_req_left != '0) && (w_fifo_count < FCNT_W'(FIFO_DEPTH));

    // Bytes are accepted only against our own outstanding request; a late byte
    // after an abort finds r_outstanding cleared and is discarded.
    assign w_push = psram_byte_valid && r_outstanding && (r_state == STREAM) && !line_abort;
    assign w_pop  = pixel_valid && pixel_ready;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        busy              = 1'b0;
        psram_set_address = 1'b0;
        case (r_state)
            IDLE: begin
                if (line_request) begin
                    w_state_nxt = SET_ADDR;
                end
            end
            SET_ADDR: begin
                busy              = 1'b1;
                psram_set_address = 1'b1;
                w_state_nxt       = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (r_remaining == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (line_abort) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_req_left    <= '0;
            r_outstanding <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= w_line_addr;
                r_remaining <= CNT_W'(BYTES_PER_LINE);
                r_req_left  <= CNT_W'(BYTES_PER_LINE);
            end
            if (w_issue) begin
                r_req_left <= r_req_left - CNT_W'(1);
            end
            if (w_push) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (line_abort) begin
                r_outstanding <= 1'b0;
            end else if (w_issue) begin
                r_outstanding <= 1'b1;
            end else if (w_push) begin
                r_outstanding <= 1'b0;
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    psram_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (sysclk),
        .i_rst   (reset),
        .i_flush (line_abort),
        .i_push  (w_push),
        .i_data  (psram_byte),
        .i_pop   (w_pop),
        .o_data  (pixel_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign pixel_valid            = !w_fifo_empty;
    assign psram_rw               = PSRAM_CMD_READ;
    assign psram_address          = r_addr;
    assign psram_next_byte_needed = w_issue;
    assign overflow               = r_overflow;
    assign underrun               = pixel_ready && !pixel_valid && busy;

`ifdef PSRAM_FETCH_UNDERRUN_COUNT_EN
    logic [15:0] r_underrun_count;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_underrun_count <= '0;
        end else if (underrun && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

endmodule
